icache_interface: RTL and testbench

Responder side of the fetch-to-instruction-cache read protocol: accepts a line read request for a PC, returns the full cache line tagged with that PC, and pulses a completion strobe. Contains a small direct-mapped, register-based line store, and refills misses from a valid/ready memory port. Sits between the fetch unit, which drives the read request and consumes `icache_out_t`, and the L2/memory adapter.

---
 rtl/icache_interface_pkg.sv | 25 ++
 rtl/icache_interface_if.sv | 35 +++
 rtl/icache_line_store.sv | 52 +++++
 rtl/icache_interface.sv | 147 ++++++++++++++
 tb/tb_icache_interface.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/icache_interface_pkg.sv
// Shared types and geometry for the instruction-cache responder.
package icache_interface_pkg;

    localparam int XLEN            = 32;
    localparam int ICACHE_OFFSET   = 4;                   // 16-byte lines
    localparam int ICACHE_LINE_LEN = 8 << ICACHE_OFFSET;  // bits per line

    typedef struct packed {
        logic [XLEN-1:0]            pc;
        logic [ICACHE_LINE_LEN-1:0] line;
    } icache_out_t;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        DRAIN
    } icache_state_t;

    // Clears the byte-offset bits so the refill address points at the line start.
    function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:ICACHE_OFFSET], {ICACHE_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_interface_if.sv
// Fetch-side and memory-side signal bundle of the instruction-cache responder.
interface icache_interface_if;
    import icache_interface_pkg::*;

    // fetch side
    logic                       flush_i;
    logic                       invalidate_i;
    logic                       read_req_i;
    logic [XLEN-1:0]            addr_i;
    logic                       read_done_o;
    icache_out_t                cache_out_o;
    // memory side
    logic                       mem_req_valid_o;
    logic                       mem_req_ready_i;
    logic [XLEN-1:0]            mem_req_addr_o;
    logic                       mem_resp_valid_i;
    logic [ICACHE_LINE_LEN-1:0] mem_resp_line_i;

    // The cache itself.
    modport slave (
        input  flush_i, invalidate_i, read_req_i, addr_i,
        output read_done_o, cache_out_o,
        output mem_req_valid_o, mem_req_addr_o,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_line_i
    );

    // Whoever drives fetch requests and plays the memory.
    modport master (
        output flush_i, invalidate_i, read_req_i, addr_i,
        input  read_done_o, cache_out_o,
        input  mem_req_valid_o, mem_req_addr_o,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_line_i
    );

endinterface

// File: rtl/icache_line_store.sv
// Direct-mapped, register-based line store: data/tag/valid arrays,
// combinational read, one write port and a bulk valid clear.
module icache_line_store
    import icache_interface_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = XLEN - ICACHE_OFFSET - IDX_W
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [IDX_W-1:0]           rd_index,
    output logic                       rd_valid,
    output logic [TAG_W-1:0]           rd_tag,
    output logic [ICACHE_LINE_LEN-1:0] rd_line,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_index,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic [ICACHE_LINE_LEN-1:0] wr_line,
    input  logic                       clear_all
);

    logic [SETS-1:0]            valid_q;
    logic [TAG_W-1:0]           tag_q  [SETS];
    logic [ICACHE_LINE_LEN-1:0] data_q [SETS];

    // Valid bits: a clear wins over a coinciding refill, so that line ends invalid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays take the refill.
    // NOTE: no reset on tag/data storage; the valid bits alone qualify their contents.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_interface.sv
// Instruction-cache responder: looks up fetch requests, refills misses from
// memory and returns {pc, line} with a one-cycle completion strobe.
module icache_interface
    import icache_interface_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    icache_interface_if.slave  bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = XLEN - ICACHE_OFFSET - IDX_W;

    icache_state_t   state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            done_q, done_d;
    icache_out_t     out_q, out_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic                       rd_valid;
    logic [TAG_W-1:0]           rd_tag;
    logic [ICACHE_LINE_LEN-1:0] rd_line;
    logic                       wr_en;
    logic                       hit;

    logic [IDX_W-1:0] lookup_index;
    logic [TAG_W-1:0] lookup_tag;

    assign lookup_index = bus.addr_i[ICACHE_OFFSET +: IDX_W];
    assign lookup_tag   = bus.addr_i[XLEN-1 -: TAG_W];
    assign hit          = rd_valid && (rd_tag == lookup_tag);

    icache_line_store #(
        .SETS (SETS),
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_store (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .rd_index (lookup_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_index (addr_q[ICACHE_OFFSET +: IDX_W]),
        .wr_tag   (addr_q[XLEN-1 -: TAG_W]),
        .wr_line  (bus.mem_resp_line_i),
        .clear_all(bus.invalidate_i)
    );

    // Next-state and next-output logic of the request FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        out_d       = out_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        wr_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.read_req_i && !bus.flush_i) begin
                    addr_d = bus.addr_i;
                    if (hit) begin
                        done_d = 1'b1;
                        out_d  = '{pc: bus.addr_i, line: rd_line};
                    end else begin
                        state_d     = MISS_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = line_align(bus.addr_i);
                    end
                end
            end
            MISS_REQ: begin
                if (bus.mem_req_ready_i) begin
                    // Once the handshake happens a response is owed, so a
                    // simultaneous flush must still drain it.
                    req_valid_d = 1'b0;
                    state_d     = bus.flush_i ? DRAIN : MISS_WAIT;
                end else if (bus.flush_i) begin
                    req_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            MISS_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                    if (!bus.flush_i) begin
                        done_d = 1'b1;
                        out_d  = '{pc: addr_q, line: bus.mem_resp_line_i};
                    end
                end else if (bus.flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_resp_valid_i) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush_i) begin
            out_d = '0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address latch and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q      <= '0;
            done_q      <= 1'b0;
            out_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            done_q      <= done_d;
            out_q       <= out_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    assign bus.read_done_o     = done_q;
    assign bus.cache_out_o     = out_q;
    assign bus.mem_req_valid_o = req_valid_q;
    assign bus.mem_req_addr_o  = req_addr_q;

endmodule

// File: tb/tb_icache_interface.sv
// Directed self-checking bench for icache_interface.
module tb_icache_interface;
    import icache_interface_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n_i;

    icache_interface_if bus();

    icache_interface #(.SETS(16)) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_vec     = 0;
    int n_err     = 0;
    int n_mem_req = 0;

    // Count accepted refill requests.
    always @(posedge clk_i) begin
        if (rst_n_i && bus.mem_req_valid_o && bus.mem_req_ready_i) n_mem_req++;
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Memory contents: a fixed pattern derived from the aligned line address.
    function automatic logic [127:0] line_for(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFF0;
        return {b, ~b, b ^ 32'h5A5A_5A5A, b + 32'h1111_1111};
    endfunction

    task automatic fetch_hit(input logic [31:0] a);
        bus.read_req_i = 1'b1;
        bus.addr_i     = a;
        step();
        check("hit_done", bus.read_done_o, 1'b1);
        check("hit_pc", bus.cache_out_o.pc, a);
        check("hit_line", bus.cache_out_o.line, line_for(a));
        check("hit_no_mem_req", bus.mem_req_valid_o, 1'b0);
        bus.read_req_i = 1'b0;
        step();
        check("hit_strobe_one_cycle", bus.read_done_o, 1'b0);
    endtask

    task automatic fetch_miss(input logic [31:0] a, input int ready_lat, input int resp_lat);
        bus.read_req_i = 1'b1;
        bus.addr_i     = a;
        step();
        check("miss_no_done", bus.read_done_o, 1'b0);
        check("miss_req_valid", bus.mem_req_valid_o, 1'b1);
        check("miss_req_addr", bus.mem_req_addr_o, a & 32'hFFFF_FFF0);
        for (int i = 1; i < ready_lat; i++) begin
            step();
            check("stall_req_valid", bus.mem_req_valid_o, 1'b1);
            check("stall_req_addr", bus.mem_req_addr_o, a & 32'hFFFF_FFF0);
        end
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        check("req_drop_after_hs", bus.mem_req_valid_o, 1'b0);
        for (int i = 0; i < resp_lat; i++) begin
            step();
            check("wait_no_done", bus.read_done_o, 1'b0);
        end
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_line_i  = line_for(a);
        step();
        bus.mem_resp_valid_i = 1'b0;
        check("refill_done", bus.read_done_o, 1'b1);
        check("refill_pc", bus.cache_out_o.pc, a);
        check("refill_line", bus.cache_out_o.line, line_for(a));
        bus.read_req_i = 1'b0;
        step();
        check("refill_strobe_one_cycle", bus.read_done_o, 1'b0);
    endtask

    initial begin
        rst_n_i              = 1'b0;
        bus.flush_i          = 1'b0;
        bus.invalidate_i     = 1'b0;
        bus.read_req_i       = 1'b0;
        bus.addr_i           = '0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_line_i  = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Reset state.
        check("rst_done", bus.read_done_o, 1'b0);
        check("rst_out", bus.cache_out_o, '0);
        check("rst_req_valid", bus.mem_req_valid_o, 1'b0);
        check("rst_req_addr", bus.mem_req_addr_o, '0);

        // Cold miss, then back-to-back hits on the same line.
        fetch_miss(32'h0000_1004, 0, 1);
        check("mem_reqs_after_cold", n_mem_req, 1);
        bus.read_req_i = 1'b1;
        bus.addr_i     = 32'h0000_1008;
        step();
        check("b2b_done0", bus.read_done_o, 1'b1);
        check("b2b_pc0", bus.cache_out_o.pc, 32'h0000_1008);
        check("b2b_line0", bus.cache_out_o.line, line_for(32'h0000_1000));
        bus.addr_i = 32'h0000_100C;
        step();
        check("b2b_done1", bus.read_done_o, 1'b1);
        check("b2b_pc1", bus.cache_out_o.pc, 32'h0000_100C);
        check("b2b_line1", bus.cache_out_o.line, line_for(32'h0000_1000));
        bus.read_req_i = 1'b0;
        step();
        check("b2b_end", bus.read_done_o, 1'b0);
        check("out_holds", bus.cache_out_o.pc, 32'h0000_100C);
        check("mem_reqs_after_b2b", n_mem_req, 1);

        // Conflict on index 0: 0x1100 evicts 0x1000 (ready stalled 5 cycles).
        fetch_hit(32'h0000_1000);
        fetch_miss(32'h0000_1100, 5, 2);
        fetch_miss(32'h0000_1000, 0, 0);
        check("mem_reqs_after_conflict", n_mem_req, 3);

        // Flush in MISS_WAIT; response arrives 3 cycles later and is drained.
        bus.read_req_i = 1'b1;
        bus.addr_i     = 32'h0000_2000;
        step();
        check("fl_req_valid", bus.mem_req_valid_o, 1'b1);
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        bus.flush_i         = 1'b1;
        bus.read_req_i      = 1'b0;
        step();
        bus.flush_i = 1'b0;
        check("fl_no_done", bus.read_done_o, 1'b0);
        check("fl_out_cleared", bus.cache_out_o, '0);
        step();
        check("fl_wait0", bus.read_done_o, 1'b0);
        step();
        check("fl_wait1", bus.read_done_o, 1'b0);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_line_i  = line_for(32'h0000_2000);
        step();
        bus.mem_resp_valid_i = 1'b0;
        check("drain_no_done", bus.read_done_o, 1'b0);
        step();
        check("drain_after", bus.read_done_o, 1'b0);
        fetch_hit(32'h0000_2004);
        check("mem_reqs_after_drain", n_mem_req, 4);

        // Flush in IDLE alongside a request: dropped, output cleared.
        bus.read_req_i = 1'b1;
        bus.addr_i     = 32'h0000_2008;
        bus.flush_i    = 1'b1;
        step();
        bus.flush_i    = 1'b0;
        bus.read_req_i = 1'b0;
        check("idle_flush_no_done", bus.read_done_o, 1'b0);
        check("idle_flush_out", bus.cache_out_o, '0);
        check("idle_flush_no_req", bus.mem_req_valid_o, 1'b0);

        // Invalidate coinciding with a hit: hit completes, line is gone afterwards.
        bus.read_req_i   = 1'b1;
        bus.addr_i       = 32'h0000_2008;
        bus.invalidate_i = 1'b1;
        step();
        bus.invalidate_i = 1'b0;
        bus.read_req_i   = 1'b0;
        check("inv_hit_done", bus.read_done_o, 1'b1);
        check("inv_hit_line", bus.cache_out_o.line, line_for(32'h0000_2000));
        step();
        fetch_miss(32'h0000_2008, 0, 1);

        // Plain invalidate pulse after warm-up.
        bus.invalidate_i = 1'b1;
        step();
        bus.invalidate_i = 1'b0;
        fetch_miss(32'h0000_200C, 2, 0);
        check("mem_reqs_final", n_mem_req, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
